gemm_seq_ctrl: RTL

//  Sequencer for the GEMM MAC datapath: walks i/j/k loops for C = A x B (NxN).

---
 rtl/gemm_seq_ctrl_if.sv | 32 +++
 rtl/gemm_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gemm_seq_ctrl_if.sv
// Handshake bundle between the GEMM sequencer and its surroundings:
// host start/busy/done, operand read strobe and addresses, MAC sequencing
// strobes, and the valid/ready result port towards the result writer.
interface gemm_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic                  mac_en;
    logic                  mac_first;
    logic                  res_valid;
    logic                  res_ready;
    logic [ADDR_WIDTH-1:0] res_addr;

    // Sequencer side
    modport master (
        input  start, res_ready,
        output busy, done, rd_en, a_addr, b_addr,
               mac_en, mac_first, res_valid, res_addr
    );

    // Host / datapath / result-writer side
    modport slave (
        output start, res_ready,
        input  busy, done, rd_en, a_addr, b_addr,
               mac_en, mac_first, res_valid, res_addr
    );
endinterface

// File: rtl/gemm_seq_ctrl.sv
// GEMM loop sequencer: walks i/j/k for C = A x B (NxN), issues A/B operand
// reads, sequences MAC clear/accumulate, and hands each C element to the
// result writer over valid/ready. One element at a time, no overlap.
// Optional macro GEMM_SEQ_CTRL_PERF_EN adds the stall_cnt output, which counts
// WRITE cycles spent waiting on res_ready.
module gemm_seq_ctrl #(
    parameter int N          = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LAT     = 1,
    parameter int MAC_LAT    = 1
) (
    input  logic clk,
    input  logic reset,
    gemm_seq_ctrl_if.master bus
`ifdef GEMM_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    // Reject configurations whose flat addresses would not fit
    if (N < 1 || (longint'(N) * longint'(N)) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_n
        $error("gemm_seq_ctrl: N*N must fit in ADDR_WIDTH and N must be >= 1");
    end
    if (RD_LAT < 1 || MAC_LAT < 1) begin : g_bad_lat
        $error("gemm_seq_ctrl: RD_LAT and MAC_LAT must be >= 1");
    end

    localparam logic [ADDR_WIDTH-1:0] N_A   = ADDR_WIDTH'(N);
    localparam logic [ADDR_WIDTH-1:0] N_M1  = ADDR_WIDTH'(N - 1);
    localparam int                    DW    = $clog2(RD_LAT + MAC_LAT + 1);
    localparam logic [DW-1:0]         DRAIN_M1 = DW'(RD_LAT + MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nx;

    logic [ADDR_WIDTH-1:0] i;
    logic [ADDR_WIDTH-1:0] j;
    logic [ADDR_WIDTH-1:0] k;
    logic [DW-1:0]         dcnt;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [ADDR_WIDTH-1:0] res_addr;
    logic [RD_LAT-1:0]     rd_pipe;
    logic [RD_LAT-1:0]     first_pipe;

    logic                  st_busy;
    logic                  st_done;
    logic                  st_rd;
    logic                  st_valid;
    logic                  accept;
    logic                  last_elem;

    assign last_elem = (i == N_M1) && (j == N_M1);

    // State register; reset aborts any run immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_nx = state;
        st_busy  = 1'b0;
        st_done  = 1'b0;
        st_rd    = 1'b0;
        st_valid = 1'b0;
        accept   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                st_busy = 1'b1;
                st_rd   = 1'b1;
                if (k == N_M1) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                st_busy = 1'b1;
                if (dcnt == DRAIN_M1) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                st_busy  = 1'b1;
                st_valid = 1'b1;
                if (bus.res_ready) begin
                    accept   = 1'b1;
                    state_nx = last_elem ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                st_done  = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Loop counters and address registers: A steps by 1, B steps by N along k
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            dcnt     <= '0;
            a_addr   <= '0;
            b_addr   <= '0;
            res_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                        a_addr <= '0;
                        b_addr <= '0;
                    end
                end
                S_RUN: begin
                    dcnt <= '0;
                    if (k != N_M1) begin
                        k      <= k + 1'b1;
                        a_addr <= a_addr + 1'b1;
                        b_addr <= b_addr + N_A;
                    end
                end
                S_DRAIN: begin
                    dcnt <= dcnt + 1'b1;
                    if (dcnt == DRAIN_M1) begin
                        res_addr <= i * N_A + j;
                    end
                end
                S_WRITE: begin
                    if (accept) begin
                        k <= '0;
                        if (j == N_M1) begin
                            j      <= '0;
                            i      <= i + 1'b1;
                            a_addr <= (i + 1'b1) * N_A;
                            b_addr <= '0;
                        end else begin
                            j      <= j + 1'b1;
                            a_addr <= i * N_A;
                            b_addr <= j + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Delay the read strobe (and its k==0 tag) to line up with operand data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pipe    <= '0;
            first_pipe <= '0;
        end else begin
            rd_pipe[0]    <= st_rd;
            first_pipe[0] <= st_rd && (k == '0);
            for (int n = 1; n < RD_LAT; n++) begin
                rd_pipe[n]    <= rd_pipe[n-1];
                first_pipe[n] <= first_pipe[n-1];
            end
        end
    end

`ifdef GEMM_SEQ_CTRL_PERF_EN
    // Count WRITE cycles stalled by the result writer; saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && bus.start) begin
            stall_cnt <= '0;
        end else if (state == S_WRITE && !bus.res_ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

    assign bus.busy      = st_busy;
    assign bus.done      = st_done;
    assign bus.rd_en     = st_rd;
    assign bus.a_addr    = a_addr;
    assign bus.b_addr    = b_addr;
    assign bus.mac_en    = rd_pipe[RD_LAT-1];
    assign bus.mac_first = first_pipe[RD_LAT-1];
    assign bus.res_valid = st_valid;
    assign bus.res_addr  = res_addr;

endmodule
